// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the RV32I five-stage pipeline: tracks in-flight
// destinations, produces the EX operand Mux4 selects, load-use stall and branch flush.
module fwd_hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int XREG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XREG_W-1:0] id_rs1,
    input  logic [XREG_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XREG_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              ex_vld;
    logic              ex_wr;
    logic              ex_ld;
    logic [XREG_W-1:0] ex_rd;
    logic              mem_vld;
    logic              mem_wr;
    logic [XREG_W-1:0] mem_rd;

    logic hit_ex_rs1;
    logic hit_ex_rs2;
    logic hit_mem_rs1;
    logic hit_mem_rs2;
    logic load_use;
    logic advance;
    logic [1:0] next_a_sel;
    logic [1:0] next_b_sel;

    function automatic logic slot_hit(input logic vld, input logic wr,
                                      input logic [XREG_W-1:0] rd,
                                      input logic [XREG_W-1:0] rs);
        return vld & wr & (rd == rs) & (rs != '0);
    endfunction

    // A load in EX cannot forward its ALU result; it is resolved from MEM/WB after the stall.
    function automatic logic [1:0] pick_sel(input logic use_rs, input logic hit_ex,
                                            input logic hit_mem, input logic ld_in_ex);
        if (use_rs & hit_ex & ~ld_in_ex) begin
            return SEL_EX;
        end else if (use_rs & hit_mem) begin
            return SEL_MEM;
        end
        return SEL_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign hit_ex_rs1  = slot_hit(ex_vld, ex_wr, ex_rd, id_rs1);
    assign hit_ex_rs2  = slot_hit(ex_vld, ex_wr, ex_rd, id_rs2);
    assign hit_mem_rs1 = slot_hit(mem_vld, mem_wr, mem_rd, id_rs1);
    assign hit_mem_rs2 = slot_hit(mem_vld, mem_wr, mem_rd, id_rs2);

    assign load_use = ex_ld & ((id_use_rs1 & hit_ex_rs1) | (id_use_rs2 & hit_ex_rs2));

    assign flush   = ex_branch_taken;
    assign stall   = id_valid & load_use & ~ex_branch_taken;
    assign advance = id_valid & ~stall & ~flush;

    assign next_a_sel = pick_sel(id_use_rs1, hit_ex_rs1, hit_mem_rs1, ex_ld);
    assign next_b_sel = pick_sel(id_use_rs2, hit_ex_rs2, hit_mem_rs2, ex_ld);

    // ID -> EX -> MEM boundary: MEM always advances; EX takes ID or becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld      <= 1'b0;
            ex_wr       <= 1'b0;
            ex_ld       <= 1'b0;
            mem_vld     <= 1'b0;
            mem_wr      <= 1'b0;
            fwd_a_sel   <= SEL_RF;
            fwd_b_sel   <= SEL_RF;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            mem_vld   <= ex_vld;
            mem_wr    <= ex_wr;
            ex_vld    <= advance;
            ex_wr     <= id_reg_write;
            ex_ld     <= id_mem_read;
            fwd_a_sel <= advance ? next_a_sel : SEL_RF;
            fwd_b_sel <= advance ? next_b_sel : SEL_RF;
            if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
            if (flush) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

    // Register indices are qualified by the slot valids, so they carry no reset.
    always_ff @(posedge clk) begin
        mem_rd <= ex_rd;
        ex_rd  <= id_rd;
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: an in-flight instruction list model checked every
// cycle, plus literal expectations for the forwarding, load-use, flush and reset cases.
module tb_fwd_hazard_ctrl;

    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs1 = '0;
    logic [4:0]    id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic [4:0]    id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          stall;
    logic          flush;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int n_chk = 0;
    int n_fail = 0;

    fwd_hazard_ctrl #(.CNT_W(CW), .XREG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Model: older[0] is the instruction now in EX (youngest), older[1] the one in MEM.
    logic       m_vld[2];
    logic [4:0] m_rd[2];
    logic       m_wr[2];
    logic       m_ld[2];
    logic [1:0] m_a;
    logic [1:0] m_b;
    int         m_sc;
    int         m_fc;

    function automatic logic exp_stall();
        if (!id_valid || ex_branch_taken) return 1'b0;
        if (!(m_vld[0] && m_wr[0] && m_ld[0]) || m_rd[0] == 5'd0) return 1'b0;
        return (id_use_rs1 && id_rs1 == m_rd[0]) || (id_use_rs2 && id_rs2 == m_rd[0]);
    endfunction

    function automatic logic enters();
        return id_valid && !ex_branch_taken && !exp_stall();
    endfunction

    // Search older instructions youngest first; the first writer of rs supplies the value.
    function automatic logic [1:0] exp_sel(input logic [4:0] rs, input logic use_rs);
        if (!use_rs || rs == 5'd0) return 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (m_vld[i] && m_wr[i] && m_rd[i] == rs) return (i == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld[0] <= 1'b0;
            m_vld[1] <= 1'b0;
            m_a      <= 2'b00;
            m_b      <= 2'b00;
            m_sc     <= 0;
            m_fc     <= 0;
        end else begin
            m_vld[1] <= m_vld[0];
            m_rd[1]  <= m_rd[0];
            m_wr[1]  <= m_wr[0];
            m_ld[1]  <= m_ld[0];
            m_vld[0] <= enters();
            m_rd[0]  <= id_rd;
            m_wr[0]  <= id_reg_write;
            m_ld[0]  <= id_mem_read;
            m_a      <= enters() ? exp_sel(id_rs1, id_use_rs1) : 2'b00;
            m_b      <= enters() ? exp_sel(id_rs2, id_use_rs2) : 2'b00;
            if (exp_stall() && m_sc < SAT) m_sc <= m_sc + 1;
            if (ex_branch_taken && m_fc < SAT) m_fc <= m_fc + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        check("cyc_stall", int'(stall), int'(exp_stall()));
        check("cyc_flush", int'(flush), int'(ex_branch_taken));
        check("cyc_fwd_a", int'(fwd_a_sel), int'(m_a));
        check("cyc_fwd_b", int'(fwd_b_sel), int'(m_b));
        check("cyc_stall_count", int'(stall_count), m_sc);
        check("cyc_flush_count", int'(flush_count), m_fc);
    endtask

    task automatic step();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic br);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_mem_read = ld; ex_branch_taken = br;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        nop();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        check("reset_stall", int'(stall), 0);
        check("reset_fwd_a", int'(fwd_a_sel), 0);
        check("reset_fwd_b", int'(fwd_b_sel), 0);
        check("reset_stall_count", int'(stall_count), 0);
        check("reset_flush_count", int'(flush_count), 0);

        // add x5 ; sub x?, x5, x6
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0); step();
        drive(1, 5'd5, 5'd6, 1, 1, 5'd8, 1, 0, 0); #1;
        check("b2b_no_stall", int'(stall), 0);
        step();
        check("b2b_fwd_a", int'(fwd_a_sel), 1);
        check("b2b_fwd_b", int'(fwd_b_sel), 0);
        nop(); step();

        // add x7 ; nop ; or rs2=x7
        drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0); step();
        nop(); step();
        drive(1, 5'd4, 5'd7, 1, 1, 5'd10, 1, 0, 0); step();
        check("dist2_fwd_b", int'(fwd_b_sel), 2);
        check("dist2_fwd_a", int'(fwd_a_sel), 0);
        drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0); step();
        nop(); step();
        drive(1, 5'd4, 5'd0, 1, 1, 5'd10, 1, 0, 0); step();
        check("dist2_x0_fwd_b", int'(fwd_b_sel), 0);

        // two writers of x3, then a reader: youngest wins
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step();
        drive(1, 5'd3, 5'd0, 1, 0, 5'd11, 1, 0, 0); step();
        check("double_fwd_a", int'(fwd_a_sel), 1);
        nop(); step();

        // lw x9 ; add rs1=x9
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0); step();
        drive(1, 5'd9, 5'd2, 1, 1, 5'd12, 1, 0, 0); #1;
        check("lu_stall", int'(stall), 1);
        check("lu_count_before", int'(stall_count), 0);
        step();
        check("lu_count_after", int'(stall_count), 1);
        check("lu_bubble_fwd_a", int'(fwd_a_sel), 0);
        check("lu_stall_released", int'(stall), 0);
        step();
        check("lu_fwd_a_mem", int'(fwd_a_sel), 2);
        nop(); step();
        drive(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0); step();
        drive(1, 5'd9, 5'd2, 0, 1, 5'd12, 1, 0, 0); #1;
        check("lu_unused_no_stall", int'(stall), 0);
        step();
        check("lu_unused_fwd_a", int'(fwd_a_sel), 0);
        check("lu_unused_count", int'(stall_count), 1);
        nop(); step();

        // branch taken while load-use holds
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0); step();
        drive(1, 5'd9, 5'd9, 1, 1, 5'd12, 1, 0, 1); #1;
        check("fl_stall", int'(stall), 0);
        check("fl_flush", int'(flush), 1);
        step();
        check("fl_flush_count", int'(flush_count), 1);
        check("fl_stall_count", int'(stall_count), 0);
        check("fl_fwd_a", int'(fwd_a_sel), 0);
        check("fl_fwd_b", int'(fwd_b_sel), 0);
        nop(); step();

        // asynchronous reset while stalled, no clock edge in between
        drive(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0); step();
        drive(1, 5'd9, 5'd0, 1, 0, 5'd12, 1, 0, 0); #1;
        check("ar_stall_before", int'(stall), 1);
        rst_n = 1'b0; #1;
        check("ar_stall", int'(stall), 0);
        check("ar_fwd_a", int'(fwd_a_sel), 0);
        check("ar_fwd_b", int'(fwd_b_sel), 0);
        check("ar_stall_count", int'(stall_count), 0);
        check("ar_flush_count", int'(flush_count), 0);
        #1; rst_n = 1'b1;
        step();
        nop(); step();

        // five load-use stalls saturate a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            drive(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0); step();
            drive(1, 5'd0, 5'd9, 0, 1, 5'd13, 1, 0, 0); step();
            step();
        end
        check("sat_stall_count", int'(stall_count), 3);
        check("sat_flush_count", int'(flush_count), 0);
        nop(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
